// File: rtl/controller_fsm.sv
// Top-level sequencer for the key-search datapath: runs task1, task2 and task3
// in order per candidate key, and stops when a key is found or the space runs out.
module controller_fsm #(
    parameter int KEY_WIDTH = 22,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX = {KEY_WIDTH{1'b1}}
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stopTask1,
    input  logic                 stopTask2,
    input  logic                 stopTask3,
    input  logic                 keyFound,
    output logic                 startTask1,
    output logic                 startTask2,
    output logic                 startTask3,
    output logic [KEY_WIDTH-1:0] secretKey,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [3:0]           debugState
);

    // Handshake: startTaskN is a one-cycle pulse issued from STARTn. The matching
    // stopTaskN is sampled only in WAITn. It may be a pulse or a level, because
    // the next START state always intervenes before that stop is looked at again.
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        START1    = 4'd1,
        WAIT1     = 4'd2,
        START2    = 4'd3,
        WAIT2     = 4'd4,
        START3    = 4'd5,
        WAIT3     = 4'd6,
        NEXT_KEY  = 4'd7,
        DONE_OK   = 4'd8,
        DONE_FAIL = 4'd9
    } stateType;

    localparam logic [KEY_WIDTH-1:0] KEY_ONE = {{(KEY_WIDTH-1){1'b0}}, 1'b1};

    stateType state;

    assign debugState = state;

    // Outputs are loaded together with the state they belong to, so they stay Moore.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            secretKey  <= '0;
            startTask1 <= 1'b0;
            startTask2 <= 1'b0;
            startTask3 <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
        end else begin
            startTask1 <= 1'b0;
            startTask2 <= 1'b0;
            startTask3 <= 1'b0;
            case (state)
                IDLE: begin
                    state      <= START1;
                    startTask1 <= 1'b1;
                    busy       <= 1'b1;
                end
                START1: state <= WAIT1;
                WAIT1: begin
                    if (stopTask1) begin
                        state      <= START2;
                        startTask2 <= 1'b1;
                    end
                end
                START2: state <= WAIT2;
                WAIT2: begin
                    if (stopTask2) begin
                        state      <= START3;
                        startTask3 <= 1'b1;
                    end
                end
                START3: state <= WAIT3;
                WAIT3: begin
                    if (stopTask3) begin
                        if (keyFound) begin
                            state <= DONE_OK;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            found <= 1'b1;
                        end else if (secretKey == KEY_MAX) begin
                            state <= DONE_FAIL;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= NEXT_KEY;
                        end
                    end
                end
                NEXT_KEY: begin
                    secretKey  <= secretKey + KEY_ONE;
                    state      <= START1;
                    startTask1 <= 1'b1;
                end
                DONE_OK, DONE_FAIL: begin
                    state <= state;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    found <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controller_fsm.sv
// Directed bench for controller_fsm: a full-width instance plus a 2-bit-key
// instance sharing the same stimulus, so that key-space exhaustion is reachable.
module tb_controller_fsm;

    localparam logic [31:0] S_IDLE      = 32'd0;
    localparam logic [31:0] S_START1    = 32'd1;
    localparam logic [31:0] S_WAIT1     = 32'd2;
    localparam logic [31:0] S_START2    = 32'd3;
    localparam logic [31:0] S_WAIT2     = 32'd4;
    localparam logic [31:0] S_DONE_OK   = 32'd8;
    localparam logic [31:0] S_DONE_FAIL = 32'd9;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic stopTask1 = 1'b0;
    logic stopTask2 = 1'b0;
    logic stopTask3 = 1'b0;
    logic keyFound = 1'b0;

    logic        startTask1, startTask2, startTask3, busy, done, found;
    logic [21:0] secretKey;
    logic [3:0]  debugState;

    logic        smStart1, smStart2, smStart3, smBusy, smDone, smFound;
    logic [1:0]  smKey;
    logic [3:0]  smState;

    int checks = 0;
    int failures = 0;
    int start1Count = 0;
    int start2Count = 0;
    int start3Count = 0;
    int smStart1Count = 0;

    controller_fsm dut (
        .clock(clock), .reset(reset),
        .stopTask1(stopTask1), .stopTask2(stopTask2), .stopTask3(stopTask3),
        .keyFound(keyFound),
        .startTask1(startTask1), .startTask2(startTask2), .startTask3(startTask3),
        .secretKey(secretKey), .busy(busy), .done(done), .found(found),
        .debugState(debugState)
    );

    controller_fsm #(.KEY_WIDTH(2)) dutSmall (
        .clock(clock), .reset(reset),
        .stopTask1(stopTask1), .stopTask2(stopTask2), .stopTask3(stopTask3),
        .keyFound(keyFound),
        .startTask1(smStart1), .startTask2(smStart2), .startTask3(smStart3),
        .secretKey(smKey), .busy(smBusy), .done(smDone), .found(smFound),
        .debugState(smState)
    );

    // Clock and pulse monitor: starts are counted on the falling edge.
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (startTask1) start1Count++;
        if (startTask2) start2Count++;
        if (startTask3) start3Count++;
        if (smStart1) smStart1Count++;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clearCounts();
        start1Count = 0;
        start2Count = 0;
        start3Count = 0;
        smStart1Count = 0;
    endtask

    // Returns on the falling edge right after reset is released (IDLE cycle).
    task automatic applyReset();
        reset = 1'b1;
        stopTask1 = 1'b0;
        stopTask2 = 1'b0;
        stopTask3 = 1'b0;
        keyFound = 1'b0;
        @(negedge clock);
        clearCounts();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic waitStart(input int n, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((n == 1 && startTask1) || (n == 2 && startTask2) || (n == 3 && startTask3)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checkVal($sformatf("%s_start%0d", tag, n), 32'(seen), 32'd1);
    endtask

    // One pass through task1..task3, each stop pulsed for one cycle inside WAITn.
    task automatic doRound(input logic verdict, input int expKey, input string tag);
        waitStart(1, tag);
        checkVal({tag, "_key"}, 32'(secretKey), 32'(expKey));
        @(negedge clock); stopTask1 = 1'b1;
        @(negedge clock); stopTask1 = 1'b0;
        waitStart(2, tag);
        @(negedge clock); stopTask2 = 1'b1;
        @(negedge clock); stopTask2 = 1'b0;
        waitStart(3, tag);
        @(negedge clock); stopTask3 = 1'b1; keyFound = verdict;
        @(negedge clock); stopTask3 = 1'b0; keyFound = 1'b0;
    endtask

    initial begin
        // Reset state, first pulse in cycle 2, then waiting forever in WAIT1.
        applyReset();
        checkVal("rst_state", 32'(debugState), S_IDLE);
        checkVal("rst_start1", 32'(startTask1), 32'd0);
        checkVal("rst_key", 32'(secretKey), 32'd0);
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_done", 32'(done), 32'd0);
        checkVal("rst_found", 32'(found), 32'd0);
        @(negedge clock);
        checkVal("t1_pulse_cycle2", 32'(startTask1), 32'd1);
        checkVal("t1_state_start1", 32'(debugState), S_START1);
        repeat (20) @(negedge clock);
        checkVal("t1_pulse_count", 32'(start1Count), 32'd1);
        checkVal("t1_state_wait1", 32'(debugState), S_WAIT1);
        checkVal("t1_busy", 32'(busy), 32'd1);
        checkVal("t1_done", 32'(done), 32'd0);

        // Stops for other tasks are ignored in WAIT1.
        stopTask2 = 1'b1; stopTask3 = 1'b1; keyFound = 1'b1;
        repeat (4) @(negedge clock);
        checkVal("t5_state", 32'(debugState), S_WAIT1);
        checkVal("t5_start2", 32'(start2Count), 32'd0);
        checkVal("t5_start3", 32'(start3Count), 32'd0);
        stopTask2 = 1'b0; stopTask3 = 1'b0; keyFound = 1'b0;

        // Single round, key found at key 0.
        applyReset();
        doRound(1'b1, 0, "t2");
        repeat (2) @(negedge clock);
        checkVal("t2_state", 32'(debugState), S_DONE_OK);
        checkVal("t2_done", 32'(done), 32'd1);
        checkVal("t2_found", 32'(found), 32'd1);
        checkVal("t2_busy", 32'(busy), 32'd0);
        checkVal("t2_key", 32'(secretKey), 32'd0);
        checkVal("t2_pulses", 32'(start1Count + start2Count + start3Count), 32'd3);

        // Level stop1 held from IDLE: one WAIT1 cycle, advances only to WAIT2.
        applyReset();
        stopTask1 = 1'b1;
        @(negedge clock);
        checkVal("lvl_start1", 32'(debugState), S_START1);
        @(negedge clock);
        checkVal("lvl_wait1", 32'(debugState), S_WAIT1);
        @(negedge clock);
        checkVal("lvl_start2", 32'(debugState), S_START2);
        repeat (5) @(negedge clock);
        checkVal("lvl_wait2", 32'(debugState), S_WAIT2);
        checkVal("lvl_s1count", 32'(start1Count), 32'd1);
        checkVal("lvl_s2count", 32'(start2Count), 32'd1);
        stopTask1 = 1'b0;

        // Three failing rounds, success on key 3.
        applyReset();
        for (int k = 0; k < 3; k++) doRound(1'b0, k, $sformatf("t3r%0d", k));
        doRound(1'b1, 3, "t3r3");
        repeat (2) @(negedge clock);
        checkVal("t3_state", 32'(debugState), S_DONE_OK);
        checkVal("t3_key", 32'(secretKey), 32'd3);
        checkVal("t3_found", 32'(found), 32'd1);
        checkVal("t3_s1count", 32'(start1Count), 32'd4);
        checkVal("t3_sm_state", 32'(smState), S_DONE_OK);
        checkVal("t3_sm_key", 32'(smKey), 32'd3);

        // Exhaustion on the 2-bit instance; the wide one moves on to key 4.
        applyReset();
        for (int k = 0; k < 4; k++) doRound(1'b0, k, $sformatf("t4r%0d", k));
        repeat (2) @(negedge clock);
        checkVal("t4_sm_state", 32'(smState), S_DONE_FAIL);
        checkVal("t4_sm_key", 32'(smKey), 32'd3);
        checkVal("t4_sm_done", 32'(smDone), 32'd1);
        checkVal("t4_sm_found", 32'(smFound), 32'd0);
        checkVal("t4_sm_busy", 32'(smBusy), 32'd0);
        checkVal("t4_sm_s1count", 32'(smStart1Count), 32'd4);
        checkVal("t4_wide_key", 32'(secretKey), 32'd4);
        checkVal("t4_wide_state", 32'(debugState), S_WAIT1);
        repeat (10) @(negedge clock);
        checkVal("t4_sm_terminal", 32'(smState), S_DONE_FAIL);

        // Asynchronous reset from WAIT2 with key 5.
        applyReset();
        for (int k = 0; k < 5; k++) doRound(1'b0, k, $sformatf("t6r%0d", k));
        waitStart(1, "t6");
        checkVal("t6_key5", 32'(secretKey), 32'd5);
        @(negedge clock); stopTask1 = 1'b1;
        @(negedge clock); stopTask1 = 1'b0;
        waitStart(2, "t6");
        @(negedge clock);
        checkVal("t6_wait2", 32'(debugState), S_WAIT2);
        #2 reset = 1'b1;
        #1;
        checkVal("t6_async_key", 32'(secretKey), 32'd0);
        checkVal("t6_async_state", 32'(debugState), S_IDLE);
        checkVal("t6_async_busy", 32'(busy), 32'd0);
        checkVal("t6_async_starts", 32'({startTask1, startTask2, startTask3}), 32'd0);
        @(negedge clock);
        clearCounts();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkVal("t6_restart_pulse", 32'(startTask1), 32'd1);
        checkVal("t6_restart_key", 32'(secretKey), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
